// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational full-subtractor cell: d = x - y - bi, with borrow out bo.
module serial_subtractor_fs (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one bit per clock through a single full-subtractor cell.
//
// Handshake: start is sampled only in IDLE; when accepted the operands are
// latched and busy stays high for WIDTH cycles, then done pulses for exactly
// one cycle while diff/bout (and flags) are final. diff/bout hold until the
// next completed operation or reset. start in BUSY/DONE is ignored.
//
// Build option: define SERSUB_FLAGS_EN to build the zr/ng/ovf status flags;
// otherwise those ports are tied to 0 and no flag logic exists.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zr,
    output logic             ng,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;     // upper result bits collected so far
    logic [WIDTH-1:0] res_nx;   // result as it would stand after this bit
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             bo_bit;
    logic             last;
    logic             accept;

    serial_subtractor_fs u_fs (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (d_bit),
        .bo (bo_bit)
    );

    assign last      = (cnt == CW'(WIDTH - 1));
    assign accept    = (state == ST_IDLE) && start;
    assign res_nx    = {d_bit, r_sh};
    assign dbg_state = state;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nx = ST_BUSY;
            ST_BUSY: begin
                busy = 1'b1;
                if (last) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand shift registers, borrow flop, counter and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
        end else if (state == ST_BUSY) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= res_nx[WIDTH-1:1];
            brw  <= bo_bit;
            cnt  <= cnt + 1'b1;
            if (last) begin
                diff <= res_nx;
                bout <= bo_bit;
            end
        end
    end

`ifdef SERSUB_FLAGS_EN
    logic sign_a;
    logic sign_b;

    // Operand signs captured at start; flags registered alongside diff.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            zr     <= 1'b0;
            ng     <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
        end else if ((state == ST_BUSY) && last) begin
            zr  <= (res_nx == '0);
            ng  <= d_bit;
            ovf <= (sign_a ^ sign_b) & (d_bit ^ sign_a);
        end
    end
`else
    assign zr  = 1'b0;
    assign ng  = 1'b0;
    assign ovf = 1'b0;
`endif

endmodule
